matrix_loader: RTL and testbench

Configuration controller that programs the cluster-lookup matrices (first matrix: hash → cluster bitmap; second matrix: cluster → hash bitmap) used by the cache-line classification core. It accepts host commands over a valid/ready handshake and arbitrates matrix ownership with the core: it holds the core off and waits for the core's pipeline to drain, then performs single read-modify-write updates or full-array clear sweeps. It sits beside the core and drives the matrices' write ports; the core keeps combinational read access.

---
 rtl/matrix_loader.sv | 158 +++++++++++++++
 tb/tb_matrix_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Host-driven programmer for the hash->cluster and cluster->hash lookup matrices.
// Optional grant timeout is compiled in with `define LOADER_TIMEOUT_EN.
module matrix_loader #(
    parameter int unsigned NUM_CLUSTERS   = 8,
    parameter int unsigned AMPLITUDE_HASH = 256,
    parameter int unsigned TAM_HASH       = $clog2(AMPLITUDE_HASH),
    parameter int unsigned GRANT_TIMEOUT  = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [1:0]                      cmd_op_i,
    input  logic [$clog2(NUM_CLUSTERS)-1:0] cmd_cluster_i,
    input  logic [TAM_HASH-1:0]             cmd_hash_i,
    input  logic                            core_busy_i,
    output logic                            core_hold_o,
    output logic                            first_we_o,
    output logic [TAM_HASH-1:0]             first_addr_o,
    output logic [NUM_CLUSTERS-1:0]         first_wdata_o,
    input  logic [NUM_CLUSTERS-1:0]         first_rdata_i,
    output logic                            second_we_o,
    output logic [$clog2(NUM_CLUSTERS)-1:0] second_addr_o,
    output logic [AMPLITUDE_HASH-1:0]       second_wdata_o,
    input  logic [AMPLITUDE_HASH-1:0]       second_rdata_i,
    output logic                            done_o,
    output logic                            err_o
);
    localparam int unsigned CW = $clog2(NUM_CLUSTERS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_GRANT, S_WRITE, S_SWEEP, S_DONE} state_e;
    typedef enum logic [1:0] {OP_SET_FIRST, OP_SET_SECOND, OP_CLEAR_ALL, OP_CLEAR_CLUSTER} op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [CW-1:0]       cluster_q, cluster_d;
    logic [TAM_HASH-1:0] hash_q, hash_d;
    logic [TAM_HASH-1:0] idx_q, idx_d;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cluster_d      = cluster_q;
        hash_d         = hash_q;
        idx_d          = idx_q;
        cmd_ready_o    = 1'b0;
        core_hold_o    = 1'b0;
        done_o         = 1'b0;
        first_we_o     = 1'b0;
        first_addr_o   = '0;
        first_wdata_o  = '0;
        second_we_o    = 1'b0;
        second_addr_o  = '0;
        second_wdata_o = '0;
`ifdef LOADER_TIMEOUT_EN
        wait_d         = '0;
        err_d          = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Ready is gated by reset so it reads 0 while reset is held.
                cmd_ready_o = rst_ni;
                if (cmd_valid_i) begin
                    op_d      = op_e'(cmd_op_i);
                    cluster_d = cmd_cluster_i;
                    hash_d    = cmd_hash_i;
                    state_d   = S_WAIT_GRANT;
                end
            end
            S_WAIT_GRANT: begin
                core_hold_o = 1'b1;
                if (!core_busy_i) begin
                    idx_d   = '0;
                    state_d = (op_q == OP_SET_FIRST || op_q == OP_SET_SECOND) ? S_WRITE : S_SWEEP;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (wait_q == TW'(GRANT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_WRITE: begin
                core_hold_o = 1'b1;
                state_d     = S_DONE;
                if (op_q == OP_SET_FIRST) begin
                    first_we_o    = 1'b1;
                    first_addr_o  = hash_q;
                    first_wdata_o = first_rdata_i | (NUM_CLUSTERS'(1) << cluster_q);
                end else if (op_q == OP_SET_SECOND) begin
                    second_we_o    = 1'b1;
                    second_addr_o  = cluster_q;
                    second_wdata_o = second_rdata_i | (AMPLITUDE_HASH'(1) << hash_q);
                end
            end
            S_SWEEP: begin
                core_hold_o  = 1'b1;
                first_we_o   = 1'b1;
                first_addr_o = idx_q;
                if (op_q == OP_CLEAR_ALL) begin
                    // Second-matrix rows are cleared during the first NUM_CLUSTERS sweep steps.
                    second_we_o   = ({1'b0, idx_q} < (TAM_HASH + 1)'(NUM_CLUSTERS));
                    second_addr_o = second_we_o ? idx_q[CW-1:0] : '0;
                end else begin
                    first_wdata_o = first_rdata_i & ~(NUM_CLUSTERS'(1) << cluster_q);
                    second_we_o   = (idx_q == '0);
                    second_addr_o = second_we_o ? cluster_q : '0;
                end
                if (idx_q == '1) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= OP_SET_FIRST;
            cluster_q <= '0;
            hash_q    <= '0;
            idx_q     <= '0;
`ifdef LOADER_TIMEOUT_EN
            wait_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cluster_q <= cluster_d;
            hash_q    <= hash_d;
            idx_q     <= idx_d;
`ifdef LOADER_TIMEOUT_EN
            wait_q    <= wait_d;
            err_q     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: table of SET commands plus hand-written sweep/reset sequences.
module tb_matrix_loader;
    logic         clk, rst_n;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_cluster;
    logic [7:0]   cmd_hash;
    logic         core_busy, core_hold;
    logic         first_we, second_we;
    logic [7:0]   first_addr, first_wdata, first_rdata;
    logic [2:0]   second_addr;
    logic [255:0] second_wdata, second_rdata;
    logic         done, err;

    logic [7:0]   fmem [256];
    logic [255:0] smem [8];
    int           ld_kind;
    logic [7:0]   ld_addr;
    logic [255:0] ld_val;

    int n_vec = 0;
    int n_err = 0;

    matrix_loader #(.NUM_CLUSTERS(8), .AMPLITUDE_HASH(256), .GRANT_TIMEOUT(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_cluster_i(cmd_cluster), .cmd_hash_i(cmd_hash),
        .core_busy_i(core_busy), .core_hold_o(core_hold),
        .first_we_o(first_we), .first_addr_o(first_addr), .first_wdata_o(first_wdata),
        .first_rdata_i(first_rdata),
        .second_we_o(second_we), .second_addr_o(second_addr), .second_wdata_o(second_wdata),
        .second_rdata_i(second_rdata),
        .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: combinational read, write on rising edge; preload port shares the process.
    assign first_rdata  = fmem[first_addr];
    assign second_rdata = smem[second_addr];
    always @(posedge clk) begin
        case (ld_kind)
            1: fmem[ld_addr] <= ld_val[7:0];
            2: for (int i = 0; i < 256; i++) fmem[i] <= ld_val[7:0];
            3: smem[ld_addr[2:0]] <= ld_val;
            4: for (int i = 0; i < 8; i++) smem[i] <= ld_val;
            default: ;
        endcase
        if (first_we)  fmem[first_addr]  <= first_wdata;
        if (second_we) smem[second_addr] <= second_wdata;
    end

    typedef struct {
        logic [1:0]   op;
        logic [2:0]   cl;
        logic [7:0]   h;
        int           busy;
        logic         keep_valid;
        logic [255:0] pre;
        logic         fwe;
        logic [7:0]   faddr;
        logic [7:0]   fwd;
        logic         swe;
        logic [2:0]   saddr;
        logic [255:0] swd;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input int kind, input logic [7:0] addr, input logic [255:0] val);
        @(negedge clk);
        ld_kind = kind; ld_addr = addr; ld_val = val;
        @(posedge clk); #1;
        ld_kind = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] cl, input logic [7:0] h, input logic busy);
        @(negedge clk);
        cmd_op = op; cmd_cluster = cl; cmd_hash = h; cmd_valid = 1'b1; core_busy = busy;
        check("ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_set(input vec_t v);
        if (v.op == 2'd0) preload(1, v.h, v.pre);
        else              preload(3, {5'd0, v.cl}, v.pre);
        issue(v.op, v.cl, v.h, v.busy > 0);
        if (!v.keep_valid) cmd_valid = 1'b0;
        for (int k = 0; k < v.busy; k++) begin
            @(negedge clk);
            check("hold_while_busy", core_hold, 1);
            check("no_we_while_busy", {first_we, second_we}, 0);
            @(posedge clk); #1;
        end
        core_busy = 1'b0;
        @(negedge clk);
        check("hold_grant_cycle", core_hold, 1);
        check("no_we_grant_cycle", {first_we, second_we}, 0);
        @(negedge clk);
        check("first_we", first_we, v.fwe);
        check("first_addr", first_addr, v.faddr);
        check("first_wdata", first_wdata, v.fwd);
        check("second_we", second_we, v.swe);
        check("second_addr", second_addr, v.saddr);
        check("second_wdata", second_wdata, v.swd);
        check("hold_write", core_hold, 1);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("hold_done", core_hold, 0);
        check("no_we_done", {first_we, second_we}, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ready_after_done", cmd_ready, 1);
        check("done_single", done, 0);
        check("err_idle", err, 0);
        if (v.keep_valid) begin
            @(negedge clk);
            check("held_valid_not_consumed", core_hold, 0);
        end
    endtask

    initial begin
        logic [255:0] top_bot;
        int bad_addr, bad_data, bad_swe, bad_sdata, nz;
        top_bot = '0; top_bot[255] = 1'b1; top_bot[0] = 1'b1;

        tbl[0] = '{2'd0, 3'd3, 8'h2A, 0,  1'b0, 256'h01, 1'b1, 8'h2A, 8'h09, 1'b0, 3'd0, 256'h0};
        tbl[1] = '{2'd1, 3'd5, 8'h07, 0,  1'b0, 256'h0,  1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 256'h80};
        tbl[2] = '{2'd0, 3'd0, 8'hFF, 10, 1'b1, 256'h80, 1'b1, 8'hFF, 8'h81, 1'b0, 3'd0, 256'h0};
        tbl[3] = '{2'd1, 3'd7, 8'hFF, 0,  1'b0, 256'h1,  1'b0, 8'h00, 8'h00, 1'b1, 3'd7, top_bot};
        tbl[4] = '{2'd0, 3'd7, 8'h00, 1,  1'b0, 256'hFF, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 256'h0};
        tbl[5] = '{2'd1, 3'd0, 8'h00, 3,  1'b0, 256'hF0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 256'hF1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cluster = '0; cmd_hash = '0;
        core_busy = 1'b0; ld_kind = 0; ld_addr = '0; ld_val = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {cmd_ready, core_hold, first_we, first_addr, first_wdata, second_we,
                                second_addr, second_wdata, done, err}, 0);
        rst_n = 1'b1;
        #1 check("ready_after_reset", cmd_ready, 1);

        for (int i = 0; i < 6; i++) run_set(tbl[i]);

        // CLEAR_ALL: full sweep of both matrices.
        preload(2, 8'h0, 256'hA5);
        preload(4, 8'h0, '1);
        issue(2'd2, 3'd4, 8'h11, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("clrall_wait_hold", core_hold, 1);
        bad_addr = 0; bad_data = 0; bad_swe = 0; bad_sdata = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!first_we || first_addr != 8'(i)) bad_addr++;
            if (first_wdata != 8'h00) bad_data++;
            if (second_we != (i < 8) || (i < 8 && second_addr != 3'(i)) || !core_hold) bad_swe++;
            if (second_wdata != '0) bad_sdata++;
            if (done) bad_swe++;
        end
        check("clrall_first_addr_seq", bad_addr, 0);
        check("clrall_first_wdata", bad_data, 0);
        check("clrall_second_we_rows", bad_swe, 0);
        check("clrall_second_wdata", bad_sdata, 0);
        @(negedge clk);
        check("clrall_done_T258", done, 1);
        check("clrall_hold_drop", core_hold, 0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (fmem[i] != 8'h00) nz++;
        for (int i = 0; i < 8; i++)   if (smem[i] != '0) nz++;
        check("clrall_matrices_zero", nz, 0);

        // CLEAR_CLUSTER 2, interrupted by reset at idx=100.
        preload(2, 8'h0, 256'hFF);
        preload(4, 8'h0, '1);
        issue(2'd3, 3'd2, 8'h33, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        bad_addr = 0; bad_data = 0; bad_swe = 0;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (!first_we || first_addr != 8'(i)) bad_addr++;
            if (first_wdata != 8'hFB) bad_data++;
            if (second_we != (i == 0) || (i == 0 && (second_addr != 3'd2 || second_wdata != '0))) bad_swe++;
        end
        check("clrcl_first_addr_seq", bad_addr, 0);
        check("clrcl_first_wdata", bad_data, 0);
        check("clrcl_single_second_we", bad_swe, 0);
        rst_n = 1'b0;
        #1 check("midsweep_reset_outputs", {cmd_ready, core_hold, first_we, first_addr, first_wdata,
                 second_we, second_addr, second_wdata, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_midsweep_reset", cmd_ready, 1);
        check("hold_after_midsweep_reset", core_hold, 0);
        nz = 0;
        for (int i = 0; i < 100; i++)   if (fmem[i] != 8'hFB) nz++;
        for (int i = 100; i < 256; i++) if (fmem[i] != 8'hFF) nz++;
        check("partial_sweep_persists", nz, 0);
        check("clrcl_second_row2", smem[2], 0);
        check("clrcl_second_row3_kept", smem[3], {256{1'b1}});
        @(negedge clk);
        check("no_restart_after_reset", {core_hold, first_we, done}, 0);

`ifdef LOADER_TIMEOUT_EN
        issue(2'd0, 3'd1, 8'h10, 1'b1);
        cmd_valid = 1'b0;
        bad_swe = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!core_hold || first_we || second_we || err) bad_swe++;
        end
        check("timeout_wait_window", bad_swe, 0);
        @(negedge clk);
        check("timeout_err", err, 1);
        check("timeout_hold_drop", core_hold, 0);
        check("timeout_no_done", done, 0);
        check("timeout_ready", cmd_ready, 1);
        core_busy = 1'b0;
        @(negedge clk);
        check("timeout_err_single", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
